// File: rtl/sfine_time_pid_if.sv
// Local-bus port bundle for sfine_time_pid. The bus master drives the
// address, strobes and write data; the block returns read data.
interface sfine_time_pid_if;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [7:0]  Address;
  logic        Read;
  logic        Write;

  modport master (output DataIn, Address, Read, Write, input DataOut);
  modport slave  (input DataIn, Address, Read, Write, output DataOut);
endinterface

// File: rtl/sfine_time_pid.sv
// Multi-channel fine-time particle ID stage. Finds the leading edge in each
// channel's latched slice pattern, classifies it against three programmable
// slice windows and keeps saturating per-class hit counters on the local bus.
module sfine_time_pid #(
  parameter int         NCH  = 4,
  parameter int         NS   = 32,
  parameter logic [7:0] BASE = 8'h00,
  parameter int         CW   = 32     // counter width; readback zero-extends to 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*NS-1:0] tl_data,
  input  logic [NCH-1:0]    tl_valid,
  output logic [NCH-1:0]    electron,
  output logic [NCH-1:0]    pion,
  output logic [NCH-1:0]    muon,
  output logic [NCH-1:0]    edge_valid,
  output logic [NCH*5-1:0]  edge_idx,
  sfine_time_pid_if.slave   bus
);

  localparam int          NE      = NS - 4;  // candidate edge positions per channel
  localparam logic [31:0] CFG_RST = 32'h0000FF0F;
  localparam logic [31:0] PW_RST  = 32'h0000F000;
  localparam logic [31:0] MW_RST  = 32'h0F000000;

  // cfg_q: {freeze, strict, muon_en, pion_en, electron_en}
  logic [4:0]     cfg_q;
  logic [NCH-1:0] chen_q;
  logic [NS-1:0]  ew_q, pw_q, mw_q;
  logic [CW-1:0]  ecnt_q, pcnt_q, mcnt_q;
  logic [NE-1:0]  edge_d [NCH];
  logic [NE-1:0]  edge_q [NCH];
  logic [NCH-1:0] e_d, p_d, m_d, v_d;
  logic [NCH*5-1:0] idx_d;

  logic [7:0] offset;
  logic       sel, wr, clr;

  assign offset = bus.Address - BASE;
  assign sel    = (offset < 8'd8);
  assign wr     = bus.Write && sel;
  assign clr    = wr && (offset[2:0] == 3'd7) && bus.DataIn[0];

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [3:0] n);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-3){1'b0}}, n};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  // Configuration and window registers, written from the local bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state is assigned with <= so every flop samples pre-edge values;
      // blocking assignments here would make results depend on statement order.
      cfg_q  <= CFG_RST[4:0];
      chen_q <= CFG_RST[8 +: NCH];
      ew_q   <= '1;
      pw_q   <= PW_RST[NS-1:0];
      mw_q   <= MW_RST[NS-1:0];
    end else if (wr) begin
      case (offset[2:0])
        3'd0: begin
          cfg_q  <= bus.DataIn[4:0];
          chen_q <= bus.DataIn[8 +: NCH];
        end
        3'd1:    ew_q <= bus.DataIn[NS-1:0];
        3'd2:    pw_q <= bus.DataIn[NS-1:0];
        3'd3:    mw_q <= bus.DataIn[NS-1:0];
        default: ;
      endcase
    end
  end

  // Edge decode: a run of ones ending at slice k+3 followed by a zero at k+4.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      edge_d[c] = '0;
      for (int k = 0; k < NE; k++) begin
        edge_d[c][k] = tl_data[c*NS+k+3] & ~tl_data[c*NS+k+4] &
                       (~cfg_q[3] | (tl_data[c*NS+k+1] & tl_data[c*NS+k+2]));
      end
      if (!tl_valid[c]) edge_d[c] = '0;
    end
  end

  // Stage 1: hold the per-channel edge vectors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) edge_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) edge_q[c] <= edge_d[c];
    end
  end

  // Window match, channel gating and lowest-edge priority encode.
  always_comb begin
    e_d   = '0;
    p_d   = '0;
    m_d   = '0;
    v_d   = '0;
    idx_d = '0;
    for (int c = 0; c < NCH; c++) begin
      e_d[c] = |(edge_q[c] & ew_q[NE-1:0]) & cfg_q[0] & chen_q[c];
      p_d[c] = |(edge_q[c] & pw_q[NE-1:0]) & cfg_q[1] & chen_q[c];
      m_d[c] = |(edge_q[c] & mw_q[NE-1:0]) & cfg_q[2] & chen_q[c];
      v_d[c] = |edge_q[c] & chen_q[c];
      if (chen_q[c]) begin
        for (int k = NE - 1; k >= 0; k--) begin
          if (edge_q[c][k]) idx_d[c*5 +: 5] = 5'(k);
        end
      end
    end
  end

  // Stage 2: registered one-cycle class pulses and edge index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      electron   <= '0;
      pion       <= '0;
      muon       <= '0;
      edge_valid <= '0;
      edge_idx   <= '0;
    end else begin
      electron   <= e_d;
      pion       <= p_d;
      muon       <= m_d;
      edge_valid <= v_d;
      edge_idx   <= idx_d;
    end
  end

  // Saturating class counters; a clear beats both freeze and same-cycle hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecnt_q <= '0;
      pcnt_q <= '0;
      mcnt_q <= '0;
    end else if (clr) begin
      ecnt_q <= '0;
      pcnt_q <= '0;
      mcnt_q <= '0;
    end else if (!cfg_q[4]) begin
      ecnt_q <= sat_add(ecnt_q, 4'($countones(e_d)));
      pcnt_q <= sat_add(pcnt_q, 4'($countones(p_d)));
      mcnt_q <= sat_add(mcnt_q, 4'($countones(m_d)));
    end
  end

  // Read mux; drives zero when not addressed so several blocks can be OR-ed.
  always_comb begin
    bus.DataOut = '0;
    if (rst && bus.Read && sel) begin
      case (offset[2:0])
        3'd0: bus.DataOut = {16'h0, 8'(chen_q), 3'b000, cfg_q};
        3'd1: bus.DataOut = 32'(ew_q);
        3'd2: bus.DataOut = 32'(pw_q);
        3'd3: bus.DataOut = 32'(mw_q);
        3'd4: bus.DataOut = 32'(ecnt_q);
        3'd5: bus.DataOut = 32'(pcnt_q);
        3'd6: bus.DataOut = 32'(mcnt_q);
        3'd7: bus.DataOut = {16'h0, 8'(NCH), 8'(NS)};
        default: bus.DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sfine_time_pid.sv
// Bench for sfine_time_pid: directed steps followed by a randomized run
// compared against a slice-rule reference model; a second instance with a
// 4-bit counter exercises saturation.
module tb_sfine_time_pid;
  localparam int NRAND = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] tl_data, tl_data_s;
  logic [3:0]   tl_valid, tl_valid_s;
  logic [3:0]   electron, pion, muon, edge_valid;
  logic [3:0]   electron_s, pion_s, muon_s, edge_valid_s;
  logic [19:0]  edge_idx, edge_idx_s;

  sfine_time_pid_if bus ();
  sfine_time_pid_if bus_s ();

  sfine_time_pid dut (
    .clk(clk), .rst(rst), .tl_data(tl_data), .tl_valid(tl_valid),
    .electron(electron), .pion(pion), .muon(muon),
    .edge_valid(edge_valid), .edge_idx(edge_idx), .bus(bus)
  );

  sfine_time_pid #(.CW(4)) dut_s (
    .clk(clk), .rst(rst), .tl_data(tl_data_s), .tl_valid(tl_valid_s),
    .electron(electron_s), .pion(pion_s), .muon(muon_s),
    .edge_valid(edge_valid_s), .edge_idx(edge_idx_s), .bus(bus_s)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  e, p, m, v;
    logic [19:0] idx;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.Address = a; bus.DataIn = d; bus.Write = 1'b1;
    tick();
    bus.Write = 1'b0;
  endtask

  task automatic wr_s(input logic [7:0] a, input logic [31:0] d);
    bus_s.Address = a; bus_s.DataIn = d; bus_s.Write = 1'b1;
    tick();
    bus_s.Write = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.Address = a; bus.Read = 1'b1;
    #1;
    chk(tag, bus.DataOut, exp);
    bus.Read = 1'b0;
  endtask

  task automatic rdchk_s(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus_s.Address = a; bus_s.Read = 1'b1;
    #1;
    chk(tag, bus_s.DataOut, exp);
    bus_s.Read = 1'b0;
  endtask

  // One capture cycle on the selected channels of the main instance.
  task automatic cap(input logic [3:0] mask, input logic [31:0] pat);
    for (int c = 0; c < 4; c++) tl_data[c*32 +: 32] = mask[c] ? pat : 32'h0;
    tl_valid = mask;
    tick();
    tl_valid = '0;
    tl_data  = '0;
  endtask

  task automatic cap_s(input logic [3:0] mask, input logic [31:0] pat);
    for (int c = 0; c < 4; c++) tl_data_s[c*32 +: 32] = mask[c] ? pat : 32'h0;
    tl_valid_s = mask;
    tick();
    tl_valid_s = '0;
    tl_data_s  = '0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e, input logic [3:0] p,
                         input logic [3:0] m, input logic [3:0] v, input logic [19:0] idx);
    chk({tag, "_cls"}, 32'({electron, pion, muon, edge_valid}), 32'({e, p, m, v}));
    chk({tag, "_idx"}, 32'(edge_idx), 32'(idx));
  endtask

  // Reference edge finder: a three-slice run of ones (strict) or a single
  // one (relaxed) immediately followed by a zero at slice k+4.
  function automatic logic [27:0] edges_of(input logic [31:0] d, input bit strict);
    logic [27:0] r;
    r = '0;
    for (int k = 0; k < 28; k++) begin
      if (strict) r[k] = (((d >> (k + 1)) & 32'hF) == 32'h7);
      else        r[k] = (((d >> (k + 3)) & 32'h3) == 32'h1);
    end
    return r;
  endfunction

  logic [31:0] r_ew, r_pw, r_mw, pat;
  logic [3:0]  r_chen;
  logic [2:0]  r_en;
  bit          r_strict, vld;
  logic [27:0] edges;
  longint unsigned me, mp, mm;
  exp_t ex;

  initial begin
    rst = 1'b0;
    tl_data = '0; tl_valid = '0; tl_data_s = '0; tl_valid_s = '0;
    bus.DataIn = '0; bus.Address = '0; bus.Read = 1'b0; bus.Write = 1'b0;
    bus_s.DataIn = '0; bus_s.Address = '0; bus_s.Read = 1'b0; bus_s.Write = 1'b0;

    // Reset state: outputs quiet and bus silent while reset is held.
    #2;
    chk_out("rst_out", 4'h0, 4'h0, 4'h0, 4'h0, 20'h0);
    rdchk("rst_dataout", 8'h01, 32'h0);
    tick(); tick();
    rst = 1'b1;
    rdchk("cfg_rst",  8'h00, 32'h00000F0F);
    rdchk("ew_rst",   8'h01, 32'hFFFFFFFF);
    rdchk("pw_rst",   8'h02, 32'h0000F000);
    rdchk("mw_rst",   8'h03, 32'h0F000000);
    rdchk("ecnt_rst", 8'h04, 32'h0);
    rdchk("ctrl_id",  8'h07, 32'h00000420);

    // Default config, strict: slices 12..15 high -> edge 12, electron+pion.
    cap(4'b0001, 32'h0000F000);
    chk_out("lat1", 4'h0, 4'h0, 4'h0, 4'h0, 20'h0);
    tick();
    chk_out("basic", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 20'd12);
    rdchk("basic_ecnt", 8'h04, 32'd1);
    rdchk("basic_pcnt", 8'h05, 32'd1);
    rdchk("basic_mcnt", 8'h06, 32'd0);
    tick();
    chk_out("pulse_width", 4'h0, 4'h0, 4'h0, 4'h0, 20'h0);

    // Relaxed mode: slices 26..27 high -> edge 24, muon window hit.
    wr(8'h00, 32'h00000F07);
    cap(4'b0100, 32'h0C000000);
    tick();
    chk_out("relaxed", 4'b0100, 4'b0000, 4'b0100, 4'b0100, {5'd0, 5'd24, 5'd0, 5'd0});
    wr(8'h00, 32'h00000F0F);
    cap(4'b0100, 32'h0C000000);
    tick();
    chk_out("strict_none", 4'h0, 4'h0, 4'h0, 4'h0, 20'h0);
    rdchk("relaxed_mcnt", 8'h06, 32'd1);

    // Channel enable 0x0E (upper enable bits beyond NCH read back 0).
    wr(8'h00, 32'h0000FE0F);
    rdchk("cfg_mask", 8'h00, 32'h00000E0F);
    cap(4'b0011, 32'h0000F000);
    tick();
    chk_out("chen", 4'b0010, 4'b0010, 4'b0000, 4'b0010, {5'd0, 5'd0, 5'd12, 5'd0});
    rdchk("chen_ecnt", 8'h04, 32'd3);
    wr(8'h04, 32'h00001234);
    rdchk("ro_write", 8'h04, 32'd3);

    // Window write on the capture cycle applies to that capture's compare.
    wr(8'h00, 32'h00000F0F);
    tl_data[31:0] = 32'h0000F000; tl_valid = 4'b0001;
    bus.Address = 8'h02; bus.DataIn = 32'h0; bus.Write = 1'b1;
    tick();
    bus.Write = 1'b0; tl_valid = '0; tl_data = '0;
    tick();
    chk_out("win_timing", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 20'd12);
    wr(8'h02, 32'h0000F000);

    // All four channels at once, then freeze.
    cap(4'b1111, 32'h0000F000);
    tick();
    chk_out("all4", 4'hF, 4'hF, 4'h0, 4'hF, {5'd12, 5'd12, 5'd12, 5'd12});
    rdchk("all4_ecnt", 8'h04, 32'd8);
    wr(8'h00, 32'h00000F1F);
    cap(4'b1111, 32'h0000F000);
    tick();
    chk_out("frozen_out", 4'hF, 4'hF, 4'h0, 4'hF, {5'd12, 5'd12, 5'd12, 5'd12});
    rdchk("frozen_ecnt", 8'h04, 32'd8);
    rdchk("frozen_pcnt", 8'h05, 32'd6);
    wr(8'h00, 32'h00000F0F);

    // Clear on the same edge as a counted hit: clear wins.
    cap(4'b1111, 32'h0000F000);
    wr(8'h07, 32'h1);
    chk_out("clr_out", 4'hF, 4'hF, 4'h0, 4'hF, {5'd12, 5'd12, 5'd12, 5'd12});
    rdchk("clr_ecnt", 8'h04, 32'd0);
    rdchk("clr_pcnt", 8'h05, 32'd0);
    tick();

    // Saturation on the 4-bit-counter instance: 4+4+4+3 = 15 = max.
    cap_s(4'b1111, 32'h0000F000);
    cap_s(4'b1111, 32'h0000F000);
    cap_s(4'b1111, 32'h0000F000);
    cap_s(4'b0111, 32'h0000F000);
    tick(); tick();
    rdchk_s("sat_max", 8'h04, 32'h0000000F);
    cap_s(4'b0001, 32'h0000F000);
    tick(); tick();
    rdchk_s("sat_hold", 8'h04, 32'h0000000F);
    cap_s(4'b0001, 32'h0000F000);
    wr_s(8'h07, 32'h1);
    rdchk_s("sat_clr", 8'h04, 32'h0);

    // Randomized run against the reference model.
    r_ew = $urandom; r_pw = $urandom; r_mw = $urandom;
    r_chen = 4'($urandom); r_en = 3'($urandom); r_strict = 1'($urandom);
    wr(8'h01, r_ew);
    wr(8'h02, r_pw);
    wr(8'h03, r_mw);
    wr(8'h00, {16'h0, 4'h0, r_chen, 3'b000, 1'b0, r_strict, r_en});
    wr(8'h07, 32'h1);
    me = 0; mp = 0; mm = 0;
    for (int i = 0; i < NRAND + 2; i++) begin
      if (i >= 2) begin
        ex = q.pop_front();
        chk_out("rnd", ex.e, ex.p, ex.m, ex.v, ex.idx);
        me = (me + $countones(ex.e) > 64'hFFFFFFFF) ? 64'hFFFFFFFF : me + $countones(ex.e);
        mp = (mp + $countones(ex.p) > 64'hFFFFFFFF) ? 64'hFFFFFFFF : mp + $countones(ex.p);
        mm = (mm + $countones(ex.m) > 64'hFFFFFFFF) ? 64'hFFFFFFFF : mm + $countones(ex.m);
        rdchk("rnd_ecnt", 8'h04, me[31:0]);
        rdchk("rnd_pcnt", 8'h05, mp[31:0]);
        rdchk("rnd_mcnt", 8'h06, mm[31:0]);
      end
      ex = '{e: '0, p: '0, m: '0, v: '0, idx: '0};
      for (int c = 0; c < 4; c++) begin
        pat = $urandom;
        vld = (i < NRAND) && ($urandom_range(3) != 0);
        tl_data[c*32 +: 32] = pat;
        tl_valid[c] = vld;
        edges = vld ? edges_of(pat, r_strict) : 28'h0;
        if (r_chen[c] && edges != 0) begin
          ex.v[c] = 1'b1;
          ex.e[c] = r_en[0] && ((edges & r_ew[27:0]) != 0);
          ex.p[c] = r_en[1] && ((edges & r_pw[27:0]) != 0);
          ex.m[c] = r_en[2] && ((edges & r_mw[27:0]) != 0);
          for (int k = 0; k < 28; k++) begin
            if (edges[k]) begin
              ex.idx[c*5 +: 5] = 5'(k);
              break;
            end
          end
        end
      end
      if (i < NRAND) q.push_back(ex);
      tick();
    end
    tl_valid = '0; tl_data = '0;

    // Reset asserted one cycle after a capture: the hit never emerges.
    cap(4'b0001, 32'h0000F000);
    rst = 1'b0;
    #1;
    chk_out("midrst_out", 4'h0, 4'h0, 4'h0, 4'h0, 20'h0);
    rdchk("midrst_dataout", 8'h01, 32'h0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out("midrst_quiet", 4'h0, 4'h0, 4'h0, 4'h0, 20'h0);
      tick();
    end
    rdchk("post_cfg",  8'h00, 32'h00000F0F);
    rdchk("post_ew",   8'h01, 32'hFFFFFFFF);
    rdchk("post_pw",   8'h02, 32'h0000F000);
    rdchk("post_mw",   8'h03, 32'h0F000000);
    rdchk("post_ecnt", 8'h04, 32'h0);
    rdchk("post_pcnt", 8'h05, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
